dp_executor: RTL and testbench
==============================

// Module: dp_executor
// PURPOSE
//  Responder end of the start_dp/instruction_dp/finished_dp/result_dp datapath protocol driven by the ant FSMs.
//  Decodes one instruction per handshake: MEMREAD, MEMWRITE, DRAW, NOP. Executes it against an internal synchronous RAM
//  or the VGA plot port, then returns result and finished. The top level muxes one initiator onto it at a time.
// PARAMETERS
//  OP_W      4    opcode field width, instruction bits [OP_W-1:0]
//  ADDR_W    10   word address width; RAM depth = 2**ADDR_W
//  DATA_W    16   RAM word / result width
//  X_W       8    VGA x width;  Y_W 7: VGA y width;  COLOUR_W 3: colour width
//  INSTR_W   32   instruction width; must be >= max(OP_W+ADDR_W+DATA_W, OP_W+X_W+Y_W+COLOUR_W+1)
//  SCREEN_W  160  SCREEN_H 120: visible area, used only with DP_CLIP_EN
// PORTS
//  clock           in   1         system clock, all logic on posedge
//  resetn          in   1         reset, synchronous, active-low
//  start_dp        in   1         request; command accepted on its rising edge only
//  instruction_dp  in   INSTR_W   instruction; sampled only on the accept cycle
//  finished_dp     out  1         1 = idle/done, 0 = busy
//  result_dp       out  DATA_W    MEMREAD data; holds until the next accepted command
//  vga_x           out  X_W       plot x
//  vga_y           out  Y_W       plot y
//  vga_colour      out  COLOUR_W  plot colour
//  vga_plot        out  1         one-cycle plot strobe
// BEHAVIOUR
//  Reset: state=IDLE, finished_dp=1, result_dp=0, vga_x/y/colour=0, vga_plot=0, start_q=0. RAM contents are not cleared.
//  Fields: op=[OP_W-1:0]; addr=[OP_W+:ADDR_W]; wdata=[OP_W+ADDR_W+:DATA_W].
//   DRAW fields, packed upward from OP_W: x, y, colour, plot bit.
//  Opcodes: 0 NOP, 1 MEMREAD, 2 MEMWRITE, 3 DRAW. Any other code executes as NOP.
//  Accept: start_q registers start_dp each cycle. accept = IDLE & start_dp & ~start_q.
//   A start_dp level held high (initiators hold it 2 cycles) produces exactly one command.
//   A rising edge while busy is ignored and never queued.
//  Accept edge k: latch instruction, finished_dp<=0, result_dp unchanged, state<=EXEC.
//  EXEC (edge k+1):
//   NOP: finished_dp<=1, state<=IDLE.
//   MEMWRITE: RAM[addr]<=wdata, finished_dp<=1, state<=IDLE.
//   DRAW: load vga_x/y/colour; vga_plot<=plot bit; finished_dp<=1; state<=IDLE.
//   MEMREAD: RAM read registered at k+1, state<=RD_CAP.
//  RD_CAP (edge k+2): result_dp<=RAM dout, finished_dp<=1, state<=IDLE.
//  Latency accept->finished_dp high: 2 cycles for MEMREAD, 1 cycle for all other ops.
//  Back-to-back: the next accept needs start_dp low for >=1 cycle, then high.
//   MEMREAD after MEMWRITE to the same address returns the new data.
//  vga_plot is high exactly one cycle (the cycle after EXEC edge), then 0. vga_x/y/colour hold their last values.
//  Address wrap: addr is exactly ADDR_W bits, so there is no out-of-range case.
//   DRAW coordinates are passed through unmodified; callers may wrap (e.g. 0-1 -> all ones).
//  Reset mid-operation: abort immediately to the reset values; a pending MEMWRITE not yet at EXEC is dropped.
// CONFIGURATION
//  DP_CLIP_EN defined: a DRAW with x>=SCREEN_W or y>=SCREEN_H suppresses vga_plot.
//   vga_x/y/colour are not updated; finished_dp timing is unchanged.
//  DP_CLIP_EN undefined: every DRAW with plot bit 1 strobes vga_plot, with no bound check.
// STRUCTURE
//  Shared package/header: opcode constants, field offset macros, state encoding (IDLE, EXEC, RD_CAP),
//   COLOUR_* constants, SCREEN_* sizes.
//  Sub-module dp_ram: single-port synchronous RAM, 2**ADDR_W x DATA_W, registered read, write-first.
//  dp_executor holds only the FSM, accept detection and output registers.
// TESTING
//  1. Reset then idle -> finished_dp=1, vga_plot=0, result_dp=0.
//  2. MEMWRITE addr 5 data 0x1234, start high 2 cycles -> one write; finished_dp low 1 cycle.
//     Then MEMREAD addr 5 -> result_dp=0x1234, finished_dp high 2 cycles after accept.
//  3. DRAW x=10 y=20 colour=3 plot=1 -> vga_plot high exactly 1 cycle with vga_x=10, vga_y=20, vga_colour=3.
//     Same DRAW with plot=0 -> no strobe.
//  4. start_dp held high 6 cycles with MEMWRITE addr 7 data 1 -> exactly one accept.
//     A second rising edge during RD_CAP of a MEMREAD is ignored.
//  5. resetn low during RD_CAP -> next edge finished_dp=1, result_dp=0. A following MEMREAD accepts normally.
//  6. With DP_CLIP_EN: DRAW x=255 y=20 -> no vga_plot, finished_dp after 1 cycle.
//     Without DP_CLIP_EN: same DRAW -> vga_plot with vga_x=255.

Source files
------------

// File: rtl/dp_executor_pkg.sv
// ---------------------------------------------------------------------------
// dp_executor_pkg
// Shared definitions for the datapath executor:
//   - default field widths of the instruction word
//   - opcode values (NOP, MEMREAD, MEMWRITE, DRAW)
//   - FSM state encoding (IDLE, EXEC, RD_CAP)
//   - VGA colour constants and visible screen size
//   - small helper used to size the instruction latch
// ---------------------------------------------------------------------------
package dp_executor_pkg;

  // Default widths of the instruction fields and outputs.
  localparam int DP_OP_W     = 4;
  localparam int DP_ADDR_W   = 10;
  localparam int DP_DATA_W   = 16;
  localparam int DP_X_W      = 8;
  localparam int DP_Y_W      = 7;
  localparam int DP_COLOUR_W = 3;
  localparam int DP_INSTR_W  = 32;

  // Visible screen area; only consulted when DRAW clipping is built in.
  localparam int DP_SCREEN_W = 160;
  localparam int DP_SCREEN_H = 120;

  // Opcodes. Codes not listed here execute as NOP.
  localparam int OP_NOP      = 0;
  localparam int OP_MEMREAD  = 1;
  localparam int OP_MEMWRITE = 2;
  localparam int OP_DRAW     = 3;

  // 3-bit RGB colours as used by the VGA adapter.
  localparam int COLOUR_BLACK   = 0;
  localparam int COLOUR_BLUE    = 1;
  localparam int COLOUR_GREEN   = 2;
  localparam int COLOUR_CYAN    = 3;
  localparam int COLOUR_RED     = 4;
  localparam int COLOUR_MAGENTA = 5;
  localparam int COLOUR_YELLOW  = 6;
  localparam int COLOUR_WHITE   = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_RD_CAP = 2'd2
  } dp_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dp_executor_if.sv
// ---------------------------------------------------------------------------
// dp_executor_if
// Request/response handshake between an ant FSM (master) and the datapath
// executor (slave).
//   start_dp        master -> slave  request, rising edge starts a command
//   instruction_dp  master -> slave  instruction word, sampled on accept
//   finished_dp     slave -> master  1 = idle/done, 0 = busy
//   result_dp       slave -> master  MEMREAD data, held until next command
// ---------------------------------------------------------------------------
interface dp_executor_if #(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 16
);

  logic               start_dp;
  logic [INSTR_W-1:0] instruction_dp;
  logic               finished_dp;
  logic [DATA_W-1:0]  result_dp;

  modport master (
    output start_dp,
    output instruction_dp,
    input  finished_dp,
    input  result_dp
  );

  modport slave (
    input  start_dp,
    input  instruction_dp,
    output finished_dp,
    output result_dp
  );

endinterface

// File: rtl/dp_executor_ram.sv
// ---------------------------------------------------------------------------
// dp_ram
// Single-port synchronous RAM, 2**ADDR_W words of DATA_W bits.
// Read data is registered; on a write the new word also appears on rdata
// (write-first). Contents are never cleared.
//   clock   in   system clock
//   we      in   write enable
//   addr    in   word address
//   wdata   in   write data
//   rdata   out  registered read data
// ---------------------------------------------------------------------------
module dp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_reg[addr] <= wdata;
      rdata_reg     <= wdata;
    end else begin
      rdata_reg <= mem_reg[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dp_executor.sv
// ---------------------------------------------------------------------------
// dp_executor
// Responder end of the start_dp/instruction_dp/finished_dp/result_dp
// protocol. Accepts one instruction per rising edge of start_dp while idle,
// executes MEMREAD / MEMWRITE / DRAW / NOP against the internal RAM or the
// VGA plot port and raises finished_dp when done.
//
// Ports
//   clock       in   system clock, posedge
//   resetn      in   synchronous active-low reset
//   dp          slave modport of dp_executor_if (handshake + result)
//   vga_x       out  plot x (holds last drawn value)
//   vga_y       out  plot y (holds last drawn value)
//   vga_colour  out  plot colour (holds last drawn value)
//   vga_plot    out  one-cycle plot strobe
//
// Build option
//   DP_CLIP_EN  when defined, a DRAW outside SCREEN_W x SCREEN_H neither
//               strobes vga_plot nor updates vga_x/y/colour.
// ---------------------------------------------------------------------------
module dp_executor
  import dp_executor_pkg::*;
#(
  parameter int OP_W     = DP_OP_W,
  parameter int ADDR_W   = DP_ADDR_W,
  parameter int DATA_W   = DP_DATA_W,
  parameter int X_W      = DP_X_W,
  parameter int Y_W      = DP_Y_W,
  parameter int COLOUR_W = DP_COLOUR_W,
  parameter int INSTR_W  = DP_INSTR_W,
  parameter int SCREEN_W = DP_SCREEN_W,
  parameter int SCREEN_H = DP_SCREEN_H
) (
  input  logic                clock,
  input  logic                resetn,
  dp_executor_if.slave        dp,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  // Field layout. Memory ops: op | addr | wdata. DRAW: op | x | y | colour | plot.
  localparam int MEM_FIELDS_W  = OP_W + ADDR_W + DATA_W;
  localparam int DRAW_FIELDS_W = OP_W + X_W + Y_W + COLOUR_W + 1;
  localparam int USED_W        = max_int(MEM_FIELDS_W, DRAW_FIELDS_W);
  localparam int ADDR_LSB      = OP_W;
  localparam int WDATA_LSB     = OP_W + ADDR_W;
  localparam int X_LSB         = OP_W;
  localparam int Y_LSB         = X_LSB + X_W;
  localparam int COLOUR_LSB    = Y_LSB + Y_W;
  localparam int PLOT_BIT      = COLOUR_LSB + COLOUR_W;

  localparam logic [OP_W-1:0] OPC_MEMREAD  = OP_W'(OP_MEMREAD);
  localparam logic [OP_W-1:0] OPC_MEMWRITE = OP_W'(OP_MEMWRITE);
  localparam logic [OP_W-1:0] OPC_DRAW     = OP_W'(OP_DRAW);

  dp_state_t           state_reg;
  logic                start_q_reg;
  logic [USED_W-1:0]   instr_reg;
  logic                finished_reg;
  logic [DATA_W-1:0]   result_reg;
  logic [X_W-1:0]      vga_x_reg;
  logic [Y_W-1:0]      vga_y_reg;
  logic [COLOUR_W-1:0] vga_colour_reg;
  logic                vga_plot_reg;

  // Only the low USED_W bits carry fields; anything above is ignored.
  generate
    if (USED_W < INSTR_W) begin : g_spare_bits
      logic unused_instr_bits;
      assign unused_instr_bits = ^dp.instruction_dp[INSTR_W-1:USED_W];
    end
  endgenerate

  // Decoded fields of the latched instruction.
  logic [OP_W-1:0]     op;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [X_W-1:0]      draw_x;
  logic [Y_W-1:0]      draw_y;
  logic [COLOUR_W-1:0] draw_colour;
  logic                draw_plot;

  assign op          = instr_reg[OP_W-1:0];
  assign mem_addr    = instr_reg[ADDR_LSB +: ADDR_W];
  assign mem_wdata   = instr_reg[WDATA_LSB +: DATA_W];
  assign draw_x      = instr_reg[X_LSB +: X_W];
  assign draw_y      = instr_reg[Y_LSB +: Y_W];
  assign draw_colour = instr_reg[COLOUR_LSB +: COLOUR_W];
  assign draw_plot   = instr_reg[PLOT_BIT];

  // A command starts only on a rising edge seen while idle; edges that
  // arrive while busy are lost, and a held-high level counts once.
  logic accept;
  assign accept = (state_reg == ST_IDLE) && dp.start_dp && !start_q_reg;

  // Whether the latched DRAW lands inside the visible area.
  logic draw_visible;
`ifdef DP_CLIP_EN
  localparam logic [X_W:0] SCREEN_W_LIM = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SCREEN_H_LIM = (Y_W + 1)'(SCREEN_H);
  assign draw_visible = ({1'b0, draw_x} < SCREEN_W_LIM) &&
                        ({1'b0, draw_y} < SCREEN_H_LIM);
`else
  // Screen size only matters for clipping; keep it referenced.
  logic unused_screen;
  assign unused_screen = ^{SCREEN_W, SCREEN_H};
  assign draw_visible  = 1'b1;
`endif

  // RAM. The write is gated by resetn so a reset that lands on the EXEC
  // edge aborts the store instead of letting it complete.
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign ram_we = resetn && (state_reg == ST_EXEC) && (op == OPC_MEMWRITE);

  dp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (ram_rdata)
  );

  // Control FSM and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      start_q_reg    <= 1'b0;
      instr_reg      <= '0;
      finished_reg   <= 1'b1;
      result_reg     <= '0;
      vga_x_reg      <= '0;
      vga_y_reg      <= '0;
      vga_colour_reg <= '0;
      vga_plot_reg   <= 1'b0;
    end else begin
      start_q_reg  <= dp.start_dp;
      vga_plot_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            instr_reg    <= dp.instruction_dp[USED_W-1:0];
            finished_reg <= 1'b0;
            state_reg    <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (op == OPC_MEMREAD) begin
            // RAM output is registered this edge; capture it next edge.
            state_reg <= ST_RD_CAP;
          end else begin
            finished_reg <= 1'b1;
            state_reg    <= ST_IDLE;
            if (op == OPC_DRAW && draw_visible) begin
              vga_x_reg      <= draw_x;
              vga_y_reg      <= draw_y;
              vga_colour_reg <= draw_colour;
              vga_plot_reg   <= draw_plot;
            end
          end
        end

        ST_RD_CAP: begin
          result_reg   <= ram_rdata;
          finished_reg <= 1'b1;
          state_reg    <= ST_IDLE;
        end

        default: begin
          finished_reg <= 1'b1;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

  assign dp.finished_dp = finished_reg;
  assign dp.result_dp   = result_reg;
  assign vga_x          = vga_x_reg;
  assign vga_y          = vga_y_reg;
  assign vga_colour     = vga_colour_reg;
  assign vga_plot       = vga_plot_reg;

endmodule

// File: tb/tb_dp_executor.sv
// ---------------------------------------------------------------------------
// tb_dp_executor
// Drives directed and random instructions through dp_executor_if and
// compares every response against a transaction-level model: a word array
// for the RAM, the last visible DRAW for the VGA outputs, and the latency
// of each opcode. Define DP_CLIP_EN for both bench and RTL to check clipping.
// ---------------------------------------------------------------------------
module tb_dp_executor;
  import dp_executor_pkg::*;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  dp_executor_if #(.INSTR_W(32), .DATA_W(16)) dp_bus ();

  dp_executor dut (
    .clock      (clock),
    .resetn     (resetn),
    .dp         (dp_bus),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [15:0] mem_model [1024];
  logic [15:0] m_result;
  logic [7:0]  m_x;
  logic [6:0]  m_y;
  logic [2:0]  m_c;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_mem(input int op, input int addr, input int data);
    logic [1:0] junk;
    junk = 2'($urandom);
    return {junk, 16'(data), 10'(addr), 4'(op)};
  endfunction

  function automatic logic [31:0] mk_draw(input int x, input int y, input int c, input int pl);
    logic [8:0] junk;
    junk = 9'($urandom);
    return {junk, 1'(pl), 3'(c), 7'(y), 8'(x), 4'(OP_DRAW)};
  endfunction

  // One full transaction: start_dp held high for 'hold' cycles, then the
  // bench watches until the command finishes and start_dp has been low.
  task automatic do_cmd(input logic [31:0] instr, input int hold, input string tag);
    logic [3:0]  op;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic        pl;
    logic        vis;
    int exp_lat, exp_plots, cyc, lat, plots, plot_cyc, relaunch;
    bit done;

    op    = instr[3:0];
    addr  = instr[13:4];
    wdata = instr[29:14];
    x     = instr[11:4];
    y     = instr[18:12];
    c     = instr[21:19];
    pl    = instr[22];

    exp_lat   = (op == 4'(OP_MEMREAD)) ? 2 : 1;
    exp_plots = 0;
    case (op)
      4'(OP_MEMREAD):  m_result = mem_model[addr];
      4'(OP_MEMWRITE): mem_model[addr] = wdata;
      4'(OP_DRAW): begin
`ifdef DP_CLIP_EN
        vis = (x < 8'd160) && (y < 7'd120);
`else
        vis = 1'b1;
`endif
        if (vis) begin
          m_x = x;
          m_y = y;
          m_c = c;
          exp_plots = pl ? 1 : 0;
        end
      end
      default: ;
    endcase

    dp_bus.instruction_dp = instr;
    dp_bus.start_dp       = 1'b1;
    @(negedge clock);
    cyc = 1; lat = 99; plots = 0; plot_cyc = 0; relaunch = 0; done = 0;
    check_val({tag, "_busy"}, 32'(dp_bus.finished_dp), 32'd0);
    while (cyc < 12 && (!done || cyc < hold + 2)) begin
      if (cyc >= hold) dp_bus.start_dp = 1'b0;
      @(negedge clock);
      cyc++;
      if (vga_plot) begin
        plots++;
        plot_cyc = cyc;
      end
      if (!done && dp_bus.finished_dp) begin
        done = 1;
        lat  = cyc - 1;
      end else if (done && !dp_bus.finished_dp) begin
        relaunch++;
      end
    end
    dp_bus.start_dp = 1'b0;

    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_plots"}, 32'(plots), 32'(exp_plots));
    if (exp_plots == 1) check_val({tag, "_plot_cyc"}, 32'(plot_cyc), 32'd2);
    check_val({tag, "_one_accept"}, 32'(relaunch), 32'd0);
    check_val({tag, "_result"}, 32'(dp_bus.result_dp), 32'(m_result));
    check_val({tag, "_vga_x"}, 32'(vga_x), 32'(m_x));
    check_val({tag, "_vga_y"}, 32'(vga_y), 32'(m_y));
    check_val({tag, "_vga_c"}, 32'(vga_colour), 32'(m_c));
    $display("tx %-10s instr=0x%08h hold=%0d lat=%0d plots=%0d result=0x%04h",
             tag, instr, hold, lat, plots, dp_bus.result_dp);
  endtask

  initial begin
    int kind, addr, op;
    dp_bus.start_dp       = 1'b0;
    dp_bus.instruction_dp = '0;
    m_result = '0; m_x = '0; m_y = '0; m_c = '0;
    foreach (mem_model[i]) mem_model[i] = '0;

    // 1. Reset then idle.
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check_val("rst_finished", 32'(dp_bus.finished_dp), 32'd1);
    check_val("rst_plot", 32'(vga_plot), 32'd0);
    check_val("rst_result", 32'(dp_bus.result_dp), 32'd0);
    check_val("rst_vga_x", 32'(vga_x), 32'd0);

    // 2. Write then read back.
    do_cmd(mk_mem(OP_MEMWRITE, 5, 16'h1234), 2, "wr5");
    do_cmd(mk_mem(OP_MEMREAD, 5, 0), 2, "rd5");

    // 3. DRAW with and without plot bit.
    do_cmd(mk_draw(10, 20, COLOUR_CYAN, 1), 2, "draw_on");
    do_cmd(mk_draw(10, 20, COLOUR_CYAN, 0), 2, "draw_off");

    // 4. Held start gives one command.
    do_cmd(mk_mem(OP_MEMWRITE, 7, 1), 6, "wr7_hold6");
    do_cmd(mk_mem(OP_MEMREAD, 7, 0), 2, "rd7");

    // 4b. Rising edge during RD_CAP is ignored (its MEMWRITE never happens).
    dp_bus.instruction_dp = mk_mem(OP_MEMREAD, 7, 0);
    dp_bus.start_dp = 1'b1;
    @(negedge clock);
    dp_bus.start_dp = 1'b0;
    @(negedge clock);
    dp_bus.instruction_dp = mk_mem(OP_MEMWRITE, 7, 16'hBEEF);
    dp_bus.start_dp = 1'b1;
    @(negedge clock);
    m_result = mem_model[7];
    check_val("rdcap_done", 32'(dp_bus.finished_dp), 32'd1);
    check_val("rdcap_result", 32'(dp_bus.result_dp), 32'(m_result));
    @(negedge clock);
    check_val("rdcap_no_accept", 32'(dp_bus.finished_dp), 32'd1);
    dp_bus.start_dp = 1'b0;
    @(negedge clock);
    check_val("rdcap_idle", 32'(dp_bus.finished_dp), 32'd1);
    $display("tx rdcap_edge ignored finished=%0b", dp_bus.finished_dp);
    do_cmd(mk_mem(OP_MEMREAD, 7, 0), 2, "rd7_again");

    // 6. Off-screen DRAW: clipped or passed through depending on build.
    do_cmd(mk_draw(255, 20, COLOUR_RED, 1), 2, "draw_x255");

    // 5. Reset during RD_CAP.
    dp_bus.instruction_dp = mk_mem(OP_MEMREAD, 5, 0);
    dp_bus.start_dp = 1'b1;
    @(negedge clock);
    dp_bus.start_dp = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    m_result = '0; m_x = '0; m_y = '0; m_c = '0;
    check_val("midrst_finished", 32'(dp_bus.finished_dp), 32'd1);
    check_val("midrst_result", 32'(dp_bus.result_dp), 32'd0);
    check_val("midrst_plot", 32'(vga_plot), 32'd0);
    $display("tx midrst finished=%0b result=0x%04h", dp_bus.finished_dp, dp_bus.result_dp);
    resetn = 1'b1;
    do_cmd(mk_mem(OP_MEMREAD, 5, 0), 2, "rd5_postrst");

    // Random phase: seed a small address set, then mix all opcodes.
    for (int a = 0; a < 9; a++) begin
      addr = (a == 8) ? 1023 : a;
      do_cmd(mk_mem(OP_MEMWRITE, addr, $urandom_range(0, 16'hFFFF)), 2, "seed_wr");
    end
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      addr = $urandom_range(0, 8);
      if (addr == 8) addr = 1023;
      if (kind <= 2)
        do_cmd(mk_mem(OP_MEMREAD, addr, $urandom_range(0, 16'hFFFF)),
               $urandom_range(1, 4), "rnd_rd");
      else if (kind <= 5)
        do_cmd(mk_mem(OP_MEMWRITE, addr, $urandom_range(0, 16'hFFFF)),
               $urandom_range(1, 4), "rnd_wr");
      else if (kind <= 8)
        do_cmd(mk_draw($urandom_range(0, 255), $urandom_range(0, 127),
                       $urandom_range(COLOUR_BLACK, COLOUR_WHITE), $urandom_range(0, 1)),
               $urandom_range(1, 4), "rnd_draw");
      else begin
        op = $urandom_range(3, 15);
        if (op == 3) op = OP_NOP;
        do_cmd(mk_mem(op, addr, $urandom_range(0, 16'hFFFF)), $urandom_range(1, 4), "rnd_nop");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
